regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2: entries per requester write queue (legal 1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req0_valid  input  1  requester 0 (memory writeback) has a write.
REQ-005 SHALL have port req0_ready  output  1  requester 0 queue can accept.
REQ-006 SHALL have port req0_addr  input  5  requester 0 destination register.
REQ-007 SHALL have port req0_data  input  32  requester 0 write value.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_addr, req1_data: same directions, widths and meanings for requester 1 (ALU writeback).
REQ-009 SHALL have port RegWrite  output  1  write strobe to register file.
REQ-010 SHALL have port WriteAddr  output  5  register file write address.
REQ-011 SHALL have port WriteData  output  32  register file write data.
REQ-012 SHALL have port pending_mask  output  32  bit a = write to register a queued or in flight.
REQ-013 SHALL have port commit_count  output  16  saturating count of committed writes.

Function
REQ-014 Handshake: transfer on reqN at a rising edge iff reqN_valid=1 and reqN_ready=1; addr/data sampled at that edge.
REQ-015 reqN_ready SHALL equal (queue N occupancy < DEPTH), independent of reqN_valid and of a same-cycle pop.
REQ-016 Transfer with addr=0 SHALL complete the handshake but be discarded: not queued, never committed, not counted.
REQ-017 Each requester queue SHALL be FIFO; per-requester commit order = acceptance order.
REQ-018 Arbitration each cycle among non-empty queue heads: one non-empty -> it is granted; both non-empty -> grant requester != last_grant (round-robin); neither -> no grant.
REQ-019 last_grant SHALL update to the granted requester on every grant, hold otherwise.
REQ-020 Granted head SHALL be popped at the edge; output register loads RegWrite=1, WriteAddr/WriteData = head addr/data at that same edge.
REQ-021 No grant at an edge -> RegWrite=0 next cycle; WriteAddr/WriteData hold last values.
REQ-022 Latency: transfer at edge E into empty queue with no contention -> RegWrite=1 during cycle after edge E+1 (one register-file write per cycle max).
REQ-023 Push and pop of same queue at same edge SHALL both take effect (occupancy unchanged).
REQ-024 pending_mask[a]=1 iff any valid queue entry targets a, or RegWrite=1 and WriteAddr=a; combinational from state; bit 0 always 0.
REQ-025 commit_count SHALL increment by 1 at each edge where RegWrite=1, saturating at 16'hFFFF.
REQ-026 Same address accepted from both requesters: both SHALL commit, order per REQ-018; no merging.
REQ-027 Throughput: both queues continuously non-empty -> grants alternate 0,1,0,1...; RegWrite=1 every cycle.

Reset
REQ-028 reset=1 SHALL immediately: empty both queues, last_grant=1 (requester 0 wins first tie), RegWrite=0, WriteAddr=0, WriteData=0, commit_count=0, pending_mask=0, req0_ready=req1_ready=0.
REQ-029 Reset mid-operation SHALL discard queued and in-flight writes without a RegWrite pulse; after release ready=1 on first cycle.

Verification
REQ-030 Single write: req0 addr=5 data=32'hDEADBEEF at edge E -> RegWrite=1, WriteAddr=5, WriteData=32'hDEADBEEF in cycle after E+1 only; pending_mask[5]=1 from E until RegWrite falls; commit_count=1.
REQ-031 Tie after reset: req0 addr=1 data=1, req1 addr=2 data=2 same edge -> commits addr 1 then addr 2 on consecutive cycles; next tie grants req0 after req1.
REQ-032 Backpressure DEPTH=2: req1 holds valid, req0 queue kept busy -> req1_ready drops after 2 accepts with contention; all queued writes commit in order, none lost.
REQ-033 r0 discard: req0 addr=0 data=32'hFFFFFFFF -> handshake completes, RegWrite never asserted, pending_mask=0, commit_count unchanged.
REQ-034 Async reset: reset asserted mid-cycle with 3 writes queued -> outputs zero before next edge; no further RegWrite; ready=1 after release.
REQ-035 Saturation: force 65537 commits -> commit_count=16'hFFFF and stays.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
// regfile_write_arbiter
//   Merges two register-file writeback streams (req0 = memory writeback,
//   req1 = ALU writeback) into a single registered write port. Each requester
//   has its own DEPTH-entry FIFO. Non-empty queue heads are arbitrated
//   round-robin, with at most one register-file write per cycle.
//
//   Ports
//     clk, reset           clock; asynchronous active-high reset
//     reqN_valid/ready     per-requester handshake (N = 0, 1)
//     reqN_addr/data       destination register / write value
//     RegWrite, WriteAddr,
//     WriteData            registered register-file write port
//     pending_mask         bit a set while a write to register a is queued or in flight
//     commit_count         saturating count of committed writes

// Per-requester write queue.
//   push_i/addr_i/data_i enqueue, pop_i dequeues the head.
//   ready_o = room available, nonempty_o = head valid,
//   pend_o  = one-hot OR of the addresses currently held.
module regfile_wq #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  output logic        ready_o,
  output logic        nonempty_o,
  output logic [4:0]  head_addr_o,
  output logic [31:0] head_data_o,
  output logic [31:0] pend_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][4:0]  addr_q;
  logic [DEPTH-1:0][31:0] data_q;
  logic [DEPTH-1:0]       vld_q;
  logic [PW-1:0]          wr_q, rd_q;
  logic [CW-1:0]          cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready is forced low while reset is held so no handshake can occur.
  assign ready_o     = !reset && (cnt_q < CW'(DEPTH));
  assign nonempty_o  = (cnt_q != '0);
  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      vld_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      // Push and pop never hit the same slot: pop needs cnt>0, push needs
      // cnt<DEPTH, so wr==rd only when exactly one of them is legal.
      if (pop_i) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= ptr_inc(rd_q);
      end
      if (push_i) begin
        addr_q[wr_q] <= addr_i;
        data_q[wr_q] <= data_i;
        vld_q[wr_q]  <= 1'b1;
        wr_q         <= ptr_inc(wr_q);
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) pend_o[addr_q[i]] = 1'b1;
  end
endmodule

module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        RegWrite,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  output logic [31:0] pending_mask,
  output logic [15:0] commit_count
);
  localparam int NREQ = 2;

  logic [NREQ-1:0]        valid_w, ready_w, push_w, pop_w, ne_w;
  logic [NREQ-1:0][4:0]   addr_w, haddr_w;
  logic [NREQ-1:0][31:0]  data_w, hdata_w, pend_w;

  assign valid_w = {req1_valid, req0_valid};
  assign addr_w  = {req1_addr,  req0_addr};
  assign data_w  = {req1_data,  req0_data};
  assign req0_ready = ready_w[0];
  assign req1_ready = ready_w[1];

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_q
      // Writes to r0 complete the handshake but are dropped here.
      assign push_w[g] = valid_w[g] && ready_w[g] && (addr_w[g] != 5'd0);
      regfile_wq #(.DEPTH(DEPTH)) u_wq (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push_w[g]),
        .addr_i     (addr_w[g]),
        .data_i     (data_w[g]),
        .pop_i      (pop_w[g]),
        .ready_o    (ready_w[g]),
        .nonempty_o (ne_w[g]),
        .head_addr_o(haddr_w[g]),
        .head_data_o(hdata_w[g]),
        .pend_o     (pend_w[g])
      );
    end
  endgenerate

  // last_q = 1 means requester 1 had the most recent grant.
  logic        rw_q, rw_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic        last_q, last_d;
  logic [15:0] cc_q, cc_d;

  // Round-robin: a lone requester always wins; on a tie the one that did
  // not win last time goes.
  assign pop_w[0] = ne_w[0] && (!ne_w[1] ||  last_q);
  assign pop_w[1] = ne_w[1] && (!ne_w[0] || !last_q);

  always_comb begin
    rw_d   = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    last_d = last_q;
    cc_d   = cc_q;
    if (pop_w[1]) begin
      rw_d = 1'b1; wa_d = haddr_w[1]; wd_d = hdata_w[1]; last_d = 1'b1;
    end else if (pop_w[0]) begin
      rw_d = 1'b1; wa_d = haddr_w[0]; wd_d = hdata_w[0]; last_d = 1'b0;
    end
    if (rw_q && (cc_q != 16'hFFFF)) cc_d = cc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      last_q <= 1'b1;
      cc_q   <= '0;
    end else begin
      rw_q   <= rw_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      last_q <= last_d;
      cc_q   <= cc_d;
    end
  end

  assign RegWrite     = rw_q;
  assign WriteAddr    = wa_q;
  assign WriteData    = wd_q;
  assign commit_count = cc_q;
  // Register 0 never holds a pending write.
  assign pending_mask = (pend_w[0] | pend_w[1] | (rw_q ? (32'd1 << wa_q) : 32'd0))
                        & ~32'd1;
endmodule
